// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter slice.
//   brMode_t : 3-bit flow-mode encoding that drives BrMode on pc_sequencer
//   PC_INCR  : byte distance between consecutive instructions
package pc_pkg;

    typedef enum logic [2:0] {
        SEQ  = 3'd0,
        CBZ  = 3'd1,
        CBZN = 3'd2,
        B    = 3'd3,
        BL   = 3'd4,
        BR   = 3'd5,
        RET  = 3'd6,
        RSVD = 3'd7
    } brMode_t;

    localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack with a saturating occupancy count.
// Ports:
//   CLK, Reset_L : clock, asynchronous active-low reset
//   push         : write push_data at top+1 (overwrites oldest when full)
//   pop          : discard top entry (ignored when empty)
//   push_data    : return address to store
//   top_data     : entry currently at the top pointer
//   empty, full  : occupancy flags from the registered count
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]    topPtr;
    logic [CW-1:0]    count;
    logic [PW-1:0]    pushPtr;
    logic             doPop;

    // RAS_DEPTH is a power of two, so pointer arithmetic wraps naturally.
    assign pushPtr  = topPtr + PW'(1);
    assign doPop    = pop && !empty;
    assign top_data = mem[topPtr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(RAS_DEPTH));

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            topPtr <= '0;
            count  <= '0;
        end else if (push) begin
            topPtr <= pushPtr;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (doPop) begin
            topPtr <= topPtr - PW'(1);
            count  <= count - CW'(1);
        end
    end

    // Entry contents need no reset; only pointer and count define validity.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[pushPtr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Registered program counter with next-PC selection and return-address stack.
// Ports:
//   CLK, Reset_L : clock, asynchronous active-low reset
//   Stall        : hold PC, RAS and fault flag this cycle
//   BrMode       : flow mode (pc_pkg::brMode_t encoding)
//   ALUZero      : zero flag for CBZ/CBNZ
//   SignExtImm   : sign-extended branch offset in words
//   RegTarget    : register target for BR
//   CurrentPC    : registered fetch address
//   NextPC       : combinational value CurrentPC takes on the next edge
//   LinkAddr     : CurrentPC + 4, link value for BL
//   RASEmpty     : return stack holds no valid entries
//   RASFault     : sticky, RET committed with an empty return stack
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned       WIDTH     = 64,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       IMM_SHIFT = 2
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             Stall,
    input  logic [2:0]       BrMode,
    input  logic             ALUZero,
    input  logic [WIDTH-1:0] SignExtImm,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] CurrentPC,
    output logic [WIDTH-1:0] NextPC,
    output logic [WIDTH-1:0] LinkAddr,
    output logic             RASEmpty,
    output logic             RASFault
);

    brMode_t          mode;
    logic [WIDTH-1:0] seqAddr;
    logic [WIDTH-1:0] branchAddr;
    logic [WIDTH-1:0] rasTop;
    logic             rasFull;
    logic             doPush;
    logic             doPop;
    logic             faultSet;

    assign mode       = brMode_t'(BrMode);
    assign seqAddr    = CurrentPC + WIDTH'(PC_INCR);
    assign branchAddr = CurrentPC + (SignExtImm << IMM_SHIFT);
    assign LinkAddr   = seqAddr;

    always_comb begin
        NextPC = seqAddr;
        case (mode)
            CBZ:     NextPC = ALUZero ? branchAddr : seqAddr;
            CBZN:    NextPC = ALUZero ? seqAddr : branchAddr;
            B:       NextPC = branchAddr;
            BL:      NextPC = branchAddr;
            BR:      NextPC = RegTarget;
            RET:     NextPC = RASEmpty ? seqAddr : rasTop;
            default: NextPC = seqAddr;
        endcase
    end

    // Stack updates and the fault flag only commit on non-stalled edges.
    assign doPush   = !Stall && (mode == BL);
    assign doPop    = !Stall && (mode == RET) && !RASEmpty;
    assign faultSet = !Stall && (mode == RET) && RASEmpty;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            CurrentPC <= RESET_PC;
            RASFault  <= 1'b0;
        end else if (!Stall) begin
            CurrentPC <= NextPC;
            if (faultSet) begin
                RASFault <= 1'b1;
            end
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) uRas (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .push      (doPush),
        .pop       (doPop),
        .push_data (seqAddr),
        .top_data  (rasTop),
        .empty     (RASEmpty),
        .full      (rasFull)
    );

    rasFlagsExclusive: assert property (@(posedge CLK) disable iff (!Reset_L)
        !(rasFull && RASEmpty));

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int unsigned WIDTH = 64;

    logic             CLK;
    logic             Reset_L;
    logic             Stall;
    logic [2:0]       BrMode;
    logic             ALUZero;
    logic [WIDTH-1:0] SignExtImm;
    logic [WIDTH-1:0] RegTarget;
    logic [WIDTH-1:0] CurrentPC;
    logic [WIDTH-1:0] NextPC;
    logic [WIDTH-1:0] LinkAddr;
    logic             RASEmpty;
    logic             RASFault;

    int assertCount;
    int failCount;

    pc_sequencer #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (4),
        .RESET_PC  ('0),
        .IMM_SHIFT (2)
    ) dut (
        .CLK        (CLK),
        .Reset_L    (Reset_L),
        .Stall      (Stall),
        .BrMode     (BrMode),
        .ALUZero    (ALUZero),
        .SignExtImm (SignExtImm),
        .RegTarget  (RegTarget),
        .CurrentPC  (CurrentPC),
        .NextPC     (NextPC),
        .LinkAddr   (LinkAddr),
        .RASEmpty   (RASEmpty),
        .RASFault   (RASFault)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkVal(input string tag, input logic [WIDTH-1:0] actual,
                            input logic [WIDTH-1:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic setPC(input logic [WIDTH-1:0] pc);
        BrMode    = 3'(BR);
        RegTarget = pc;
        stepCycle();
        BrMode    = 3'(SEQ);
    endtask

    task automatic doBL(input logic [WIDTH-1:0] imm);
        BrMode     = 3'(BL);
        SignExtImm = imm;
        stepCycle();
        BrMode     = 3'(SEQ);
    endtask

    task automatic doRET();
        BrMode = 3'(RET);
        stepCycle();
        BrMode = 3'(SEQ);
    endtask

    logic [WIDTH-1:0] callPC [5];

    initial begin
        assertCount = 0;
        failCount   = 0;
        Reset_L     = 1'b1;
        Stall       = 1'b0;
        BrMode      = 3'(SEQ);
        ALUZero     = 1'b0;
        SignExtImm  = '0;
        RegTarget   = '0;

        // Reset then sequential flow
        #1 Reset_L = 1'b0;
        #10;
        checkVal("rstPC", CurrentPC, 64'h0);
        checkVal("rstEmpty", 64'(RASEmpty), 64'h1);
        checkVal("rstFault", 64'(RASFault), 64'h0);
        @(negedge CLK);
        Reset_L = 1'b1;
        stepCycle();
        checkVal("seq1", CurrentPC, 64'h4);
        stepCycle();
        checkVal("seq2", CurrentPC, 64'h8);
        stepCycle();
        checkVal("seq3", CurrentPC, 64'hC);
        checkVal("seqEmpty", 64'(RASEmpty), 64'h1);

        // Conditional branches, offset -2 words
        setPC(64'h100);
        checkVal("setPC100", CurrentPC, 64'h100);
        BrMode     = 3'(CBZ);
        SignExtImm = 64'hFFFF_FFFF_FFFF_FFFE;
        ALUZero    = 1'b1;
        #1 checkVal("cbzTaken", NextPC, 64'hF8);
        ALUZero = 1'b0;
        #1 checkVal("cbzNotTaken", NextPC, 64'h104);
        BrMode  = 3'(CBZN);
        #1 checkVal("cbnzTaken", NextPC, 64'hF8);
        ALUZero = 1'b1;
        #1 checkVal("cbnzNotTaken", NextPC, 64'h104);
        ALUZero = 1'b0;
        stepCycle();
        checkVal("cbnzCommit", CurrentPC, 64'hF8);
        BrMode = 3'(B);
        SignExtImm = 64'h3;
        #1 checkVal("bUncond", NextPC, 64'h104);
        BrMode = 3'(SEQ);

        // Call / return
        setPC(64'h200);
        BrMode     = 3'(BL);
        SignExtImm = 64'h10;
        #1 checkVal("blLink", LinkAddr, 64'h204);
        stepCycle();
        BrMode = 3'(SEQ);
        checkVal("blPC", CurrentPC, 64'h240);
        checkVal("blEmpty", 64'(RASEmpty), 64'h0);
        doRET();
        checkVal("retPC", CurrentPC, 64'h204);
        checkVal("retEmpty", 64'(RASEmpty), 64'h1);
        checkVal("retFault", 64'(RASFault), 64'h0);

        // Stalled BL leaves PC and stack untouched
        setPC(64'h300);
        Stall      = 1'b1;
        BrMode     = 3'(BL);
        SignExtImm = 64'h4;
        stepCycle();
        stepCycle();
        checkVal("stallPC", CurrentPC, 64'h300);
        checkVal("stallEmpty", 64'(RASEmpty), 64'h1);
        BrMode = 3'(RET);
        stepCycle();
        checkVal("stallRetFault", 64'(RASFault), 64'h0);
        Stall  = 1'b0;
        BrMode = 3'(SEQ);

        // Overflow: five calls into a four-deep stack
        for (int i = 0; i < 5; i++) begin
            callPC[i] = 64'h1000 + 64'(i) * 64'h100;
            setPC(callPC[i]);
            doBL(64'h1);
        end
        for (int i = 4; i >= 1; i--) begin
            doRET();
            checkVal($sformatf("ovfRet%0d", i), CurrentPC, callPC[i] + 64'h4);
        end
        checkVal("ovfEmpty", 64'(RASEmpty), 64'h1);
        checkVal("ovfNoFault", 64'(RASFault), 64'h0);
        doRET();
        checkVal("emptyRetPC", CurrentPC, 64'h1108);
        checkVal("emptyRetFault", 64'(RASFault), 64'h1);
        stepCycle();
        checkVal("faultSticky", 64'(RASFault), 64'h1);

        // Wrap, register branch, reserved mode
        setPC(64'hFFFF_FFFF_FFFF_FFFC);
        stepCycle();
        checkVal("wrapPC", CurrentPC, 64'h0);
        setPC(64'h1234);
        checkVal("brPC", CurrentPC, 64'h1234);
        BrMode = 3'(RSVD);
        stepCycle();
        BrMode = 3'(SEQ);
        checkVal("rsvdPC", CurrentPC, 64'h1238);

        // Reset mid-operation
        doBL(64'h1);
        doBL(64'h1);
        checkVal("midBLPC", CurrentPC, 64'h1240);
        checkVal("midEmpty", 64'(RASEmpty), 64'h0);
        #3 Reset_L = 1'b0;
        #1;
        checkVal("midRstPC", CurrentPC, 64'h0);
        checkVal("midRstEmpty", 64'(RASEmpty), 64'h1);
        checkVal("midRstFault", 64'(RASFault), 64'h0);
        @(negedge CLK);
        Reset_L = 1'b1;
        doRET();
        checkVal("postRstRetPC", CurrentPC, 64'h4);
        checkVal("postRstFault", 64'(RASFault), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Registered program-counter unit for the next core generation; replaces purely combinational next-PC selection.
- Holds the PC register and computes next PC for sequential, conditional (CBZ/CBNZ), unconditional (B), link (BL), register (BR) and return (RET) flow.
- Contains a parametrised return-address stack (RAS) and a stall hold.
- Sits between fetch (drives instruction-memory address) and control/ALU (supply mode, ALUZero, immediate, register target).

Parameters:
WIDTH, 64, address/PC width in bits
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset
IMM_SHIFT, 2, left shift applied to branch immediate (word offset to byte offset)

Ports:
CLK  input  1  rising-edge clock
Reset_L  input  1  asynchronous active-low reset
Stall  input  1  1 = hold PC and RAS this cycle
BrMode  input  3  flow mode, encoding in package
ALUZero  input  1  zero flag from ALU for CBZ/CBNZ
SignExtImm  input  WIDTH  sign-extended branch offset, in words
RegTarget  input  WIDTH  register value for BR
CurrentPC  output  WIDTH  registered PC, instruction fetch address
NextPC  output  WIDTH  combinational PC value for the next edge
LinkAddr  output  WIDTH  CurrentPC+4, for link-register write on BL
RASEmpty  output  1  RAS holds zero valid entries
RASFault  output  1  sticky: RET executed with RAS empty

Behaviour:
- Reset (Reset_L=0, asynchronous, immediate):
  - CurrentPC=RESET_PC; RAS count=0, top pointer=0; RASFault=0; RASEmpty=1.
  - RAS entry contents are don't-care.
- Arithmetic:
  - SeqAddr = CurrentPC+4, mod 2^WIDTH.
  - BranchAddr = CurrentPC + (SignExtImm<<IMM_SHIFT), truncated to WIDTH, mod 2^WIDTH (wrap allowed).
- NextPC by BrMode:
  - SEQ(0): SeqAddr.
  - CBZ(1): BranchAddr if ALUZero=1, else SeqAddr.
  - CBNZ(2): BranchAddr if ALUZero=0, else SeqAddr.
  - B(3): BranchAddr.
  - BL(4): BranchAddr; push SeqAddr.
  - BR(5): RegTarget, used unmodified with no alignment check.
  - RET(6): RAS top if count>0 and pop; if count=0, SeqAddr, and set RASFault.
  - 7: reserved, treated as SEQ.
- Update: on rising CLK with Stall=0, CurrentPC<=NextPC, and RAS push/pop commits.
  - Stall=1: CurrentPC, RAS and RASFault all unchanged, regardless of BrMode.
- Latency: NextPC and LinkAddr are combinational from current state and inputs; CurrentPC reflects them one cycle later.
- RAS:
  - Circular LIFO.
  - Push writes at top+1 and increments count, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry (wrap), count stays RAS_DEPTH.
  - Pop reads top, decrements pointer and count.
  - Push and pop never occur in the same cycle (mode-exclusive).
- RASFault: set on the edge that commits RET with empty RAS; cleared only by reset.
- RASEmpty = (count==0), combinational from registered count.

Decomposition:
- Shared package pc_pkg:
  - BrMode enum (SEQ, CBZ, CBZN, B, BL, BR, RET, RSVD) with the 3-bit encodings above.
  - Constant PC_INCR=4.
- One sub-module: pc_ras.
  - Parameters WIDTH and RAS_DEPTH.
  - Ports: push, pop, push_data, top_data, empty, full, CLK, Reset_L.
  - Holds storage, pointer and saturating count.
- pc_sequencer holds the mode decode, adders, PC register and fault flag.

Test Plan:
- Reset then SEQ: Reset_L low, release with Stall=0, BrMode=0 for 3 edges -> CurrentPC 0,4,8,12; RASEmpty=1.
- Conditional: PC=0x100, BrMode=CBZ, SignExtImm=-2, ALUZero=1 -> next PC 0xF8. Same with ALUZero=0 -> 0x104. CBNZ with ALUZero=0 -> 0xF8.
- Call/return: PC=0x200, BL with imm=0x10 -> PC 0x240, LinkAddr was 0x204, RASEmpty=0. Then RET -> PC 0x204, RASEmpty=1, RASFault=0.
- RAS overflow (RAS_DEPTH=4): five BLs from PCs A0..A4 (return addresses A0+4..A4+4). Then four RETs -> A4+4, A3+4, A2+4, A1+4. Fifth RET -> SeqAddr, RASFault=1 and stays 1.
- Stall and wrap:
  - BL with Stall=1 for 2 cycles -> CurrentPC and RAS unchanged.
  - PC=0xFFFF_FFFF_FFFF_FFFC with SEQ -> PC wraps to 0.
  - BR with RegTarget=0x1234 -> PC 0x1234.
- Reset mid-operation: after two BLs, assert Reset_L low between edges -> CurrentPC=RESET_PC immediately, RASEmpty=1, RASFault=0. A subsequent RET sets RASFault.
